// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipe.
package reg_pipe_pkg;

  localparam logic [7:0]  PIPE_DEFAULT_RESET = 8'h34;
  localparam int unsigned PIPE_MAX_DEPTH     = 16;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipe stage: a data register plus its valid bit.
// Ports: clk, reset (sync, active-high), flush, adv (stage may load),
//        up_valid/up_data (from the stage behind or the input port),
//        data/valid (registered stage contents).
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = PIPE_DEFAULT_RESET,
  parameter bit               CLK_NEGEDGE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_d;
  logic             valid_d;

  // Data only loads on a valid word so bubbles leave the register untouched.
  always_comb begin
    data_d  = data;
    valid_d = valid;
    if (flush) begin
      data_d  = RESET_VALUE;
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  if (CLK_NEGEDGE) begin : g_neg
    always_ff @(negedge clk) begin
      if (reset) begin
        data  <= RESET_VALUE;
        valid <= 1'b0;
      end else begin
        data  <= data_d;
        valid <= valid_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk) begin
      if (reset) begin
        data  <= RESET_VALUE;
        valid <= 1'b0;
      end else begin
        data  <= data_d;
        valid <= valid_d;
      end
    end
  end

endmodule

// File: rtl/reg_pipe_elastic.sv
// Elastic delay line of DEPTH register stages with valid/ready flow control.
// Ports: clk, reset (sync, active-high), in_data/in_valid/in_ready (upstream),
//        out_data/out_valid/out_ready (downstream), flush (sync clear),
//        count (number of valid stages).
module reg_pipe_elastic
  import reg_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = PIPE_DEFAULT_RESET,
  parameter bit               CLK_NEGEDGE = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH:0]   adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Combinational ready chain: an empty stage can always load, so bubbles collapse.
  assign adv[DEPTH] = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    assign adv[g] = !stage_valid[g] || adv[g+1];

    if (g == 0) begin : g_head
      assign up_valid = in_xfer;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = stage_valid[g-1];
      assign up_data  = stage_data[g-1];
    end

    reg_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE),
      .CLK_NEGEDGE (CLK_NEGEDGE)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .adv      (adv[g]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .data     (stage_data[g]),
      .valid    (stage_valid[g])
    );
  end

  assign in_ready  = adv[0] && !flush && !reset;
  assign in_xfer   = in_valid && in_ready;
  assign out_data  = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d = '0;
    end
  end

  if (CLK_NEGEDGE) begin : g_cnt_neg
    always_ff @(negedge clk) begin
      if (reset) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end
  end else begin : g_cnt_pos
    always_ff @(posedge clk) begin
      if (reset) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end
  end

endmodule

// File: doc/reg_pipe_elastic.md
Name: reg_pipe_elastic

Overview:
- Parametrised successor to the team's single-stage resettable data register.
- Chain of DEPTH data registers with per-stage valid bits and valid/ready flow control. Bubbles collapse under back-pressure.
- Keeps the programmable reset value and selectable clock edge. Adds flush and an occupancy count.
- Used wherever a fixed-latency, stallable delay line sits between two handshaking blocks.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 3: number of register stages; legal range 1..16.
- RESET_VALUE, 8'h34 (WIDTH bits): value loaded into every stage's data register on reset and on flush.
- CLK_NEGEDGE, 1: 1 means all state updates on the falling edge of clk; 0 means the rising edge.

Ports:
- clk  input  1  single clock; active edge is selected by CLK_NEGEDGE.
- reset  input  1  synchronous, active-high reset; sampled on the active clk edge.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data is valid.
- in_ready  output  1  the pipe accepts in_data this cycle.
- out_data  output  WIDTH  data in the last stage.
- out_valid  output  1  the last stage holds valid data.
- out_ready  input  1  downstream accepts out_data.
- flush  input  1  synchronous clear of all stages; does not reset configuration.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset. All flops update only on the active clk edge.
- Reset:
  - Every stage data register becomes RESET_VALUE and every valid bit becomes 0.
  - Outputs: out_data = RESET_VALUE, out_valid = 0, count = 0, in_ready = 1 (combinational, once reset is low).
- Stage i (0 = input side, DEPTH-1 = output side) holds data_i and v_i.
- adv_i = !v_i || adv_(i+1). At the output end, adv_(DEPTH) = out_ready.
  - This ready chain is combinational. No registered skid is required.
- in_ready = adv_0 && !flush && !reset.
- On the active edge, when adv_i is true:
  - Stage i loads from stage i-1, or from the input port for stage 0: data and valid.
  - Data is loaded only when the incoming valid is 1. Otherwise data_i holds its value and v_i becomes 0.
  - This rule keeps data stable on bubbles and saves toggling.
- When adv_i is false, stage i holds both data_i and v_i.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - out_data and out_valid come directly from stage DEPTH-1 flops. There is no combinational path from in_* to out_*.
- Latency: with out_ready held at 1 and no stalls, a word accepted at edge N appears on out_data after edge N+DEPTH-1.
  - The word is valid on out_* during the cycle following that edge, so a 3-stage pipe presents it 3 edges after presentation.
- Throughput: one word per cycle when out_ready = 1.
- Full pipe with out_ready = 0: all v_i = 1, so in_ready = 0 and contents hold unchanged.
- Bubble collapse: with out_ready = 0, any empty stage still accepts from the stage behind it.
- Full pipe with out_ready = 1: the pipe shifts, and in_ready = 1 in the same cycle (simultaneous push and pop).
- count:
  - Registered. Increments on input transfer only, decrements on output transfer only, and is unchanged when both or neither occur.
  - Invariant: count equals popcount(v) at all times.
  - Saturates at DEPTH by construction; no overflow is possible.
- flush:
  - On the edge with flush = 1, all v_i = 0, all data_i = RESET_VALUE, and count = 0.
  - in_ready = 0 during flush, so no input word is accepted or lost.
  - An output transfer that is coincident with flush still counts as delivered downstream.
- Priority: reset > flush > normal operation.
- Reset asserted mid-stream: all in-flight data is discarded on that edge, identical to the reset state.
- DEPTH = 1: a single register; in_ready = !v_0 || out_ready.

Decomposition:
- Package reg_pipe_pkg:
  - Constant PIPE_DEFAULT_RESET = 8'h34.
  - Constant PIPE_MAX_DEPTH = 16.
  - Function cnt_width(depth) returning $clog2(depth+1).
- Sub-module reg_pipe_stage:
  - Holds one data register and one valid bit.
  - Inputs: adv, up_valid, up_data, flush, reset.
  - Parameters: WIDTH, RESET_VALUE, CLK_NEGEDGE.
- The top level generates DEPTH instances, the adv chain and the count register.

Test Plan:
- Reset with WIDTH=8, DEPTH=3: assert reset for 2 edges -> out_data = 8'h34, out_valid = 0, count = 0, in_ready = 1.
- Streaming with out_ready = 1: send 8'h01, 8'h02, 8'h03, 8'h04 on consecutive edges -> out_valid rises 3 edges after the first push, out_data is 01,02,03,04 on consecutive cycles, and count stays at 3 in steady state.
- Back-pressure with out_ready = 0: push 8'hA0, then 8'hA1, 8'hA2, 8'hA3 -> after 3 accepts in_ready = 0 and count = 3; releasing out_ready delivers A0, A1, A2, then A3 is accepted, with no loss or duplication.
- Bubble collapse: push 8'h11, idle 2 cycles, push 8'h22, out_ready = 0 -> both words pack into the two output-side stages and count = 2.
- Flush with the pipe full (count = 3) and in_valid = 1 with in_data = 8'hFF -> next cycle count = 0, out_valid = 0, out_data = 8'h34, and 8'hFF is never output.
- CLK_NEGEDGE = 0 build, reset asserted mid-stream with 2 words in flight -> state clears on the next rising edge, and falling edges cause no updates.
